// File: rtl/vga_timing_counter.sv
// Pixel-clock divider and horizontal/vertical position counters for 640x480@60 VGA timing.
// Define FRAME_COUNT_EN to add the 8-bit frame_count output and its register.
module vga_timing_counter #(
    parameter int CLK_DIV  = 4,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    output logic       pixel_tick,
    output logic [9:0] h_count,
    output logic [9:0] v_count,
    output logic       hsync,
    output logic       vsync,
    output logic       active,
    output logic       line_end,
`ifdef FRAME_COUNT_EN
    output logic       frame_end,
    output logic [7:0] frame_count
`else
    output logic       frame_end
`endif
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
    localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
    localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

    // A one-clock divider still needs a 1-bit register; it simply never leaves 0.
    localparam int                DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt;
    logic [9:0]       h_next;
    logic [9:0]       v_next;
    logic             h_wrap;
    logic             v_wrap;

    // Reset is gated in so the strobes read 0 while reset is held, even with CLK_DIV=1.
    assign pixel_tick = enable & ~reset & (div_cnt == DIV_LAST);
    assign h_wrap     = (h_count == H_LAST);
    assign v_wrap     = (v_count == V_LAST);
    assign line_end   = pixel_tick & h_wrap;
    assign frame_end  = line_end & v_wrap;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        h_next = h_count;
        v_next = v_count;
        if (pixel_tick) begin
            h_next = h_wrap ? 10'd0 : h_count + 10'd1;
            if (h_wrap) begin
                v_next = v_wrap ? 10'd0 : v_count + 10'd1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt <= '0;
        end else if (enable) begin
            div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
        end
    end

    // Decodes are taken from the next counts so they line up with the counts they describe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_count <= 10'd0;
            v_count <= 10'd0;
            hsync   <= 1'b1;
            vsync   <= 1'b1;
            active  <= 1'b1;
        end else begin
            h_count <= h_next;
            v_count <= v_next;
            hsync   <= ~((h_next >= HS_START) && (h_next <= HS_END));
            vsync   <= ~((v_next >= VS_START) && (v_next <= VS_END));
            active  <= (h_next < H_VIS) && (v_next < V_VIS);
        end
    end

`ifdef FRAME_COUNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_count <= 8'd0;
        end else if (frame_end) begin
            frame_count <= frame_count + 8'd1;
        end
    end
`endif

endmodule
